// File: rtl/alu_pkg.sv
// Shared definitions for the ALU and its writeback stage: op codes, status-flag
// bit positions, the buffered writeback entry and the per-result flag computation.
package alu_pkg;

    localparam int WIDTH = 16;
    localparam int AW    = 3;
    localparam int DEPTH = 2;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_MUL = 3'b100;
    localparam logic [2:0] OP_DIV = 3'b101;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    // One result waiting to retire, with its flags already resolved at capture time.
    typedef struct packed {
        logic [WIDTH-1:0] result;
        logic [AW-1:0]    rd;
        logic             wr_en;
        logic             flags_en;
        logic [3:0]       nzcv;
    } wb_entry_t;

    localparam int ENTRY_W = $bits(wb_entry_t);

    // Flags of a result. Carry and overflow only carry meaning for ADD/SUB;
    // every other op code, including the unassigned 110/111, reports them as zero.
    function automatic logic [3:0] calc_nzcv(
        input logic [WIDTH-1:0] result,
        input logic [2:0]       op,
        input logic             cout,
        input logic             overflow
    );
        logic [3:0] f;
        f         = 4'b0000;
        f[FLAG_N] = result[WIDTH-1];
        f[FLAG_Z] = (result == {WIDTH{1'b0}});
        case (op)
            OP_ADD, OP_SUB: begin
                f[FLAG_C] = cout;
                f[FLAG_V] = overflow;
            end
            default: begin
                f[FLAG_C] = 1'b0;
                f[FLAG_V] = 1'b0;
            end
        endcase
        return f;
    endfunction

endpackage

// File: rtl/alu_writeback_stage_if.sv
// ALU-to-writeback and writeback-to-register-file handshake bundle.
// master = the surrounding ALU / register file, slave = the writeback stage.
interface alu_writeback_stage_if;
    import alu_pkg::*;

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_result;
    logic             in_cout;
    logic             in_overflow;
    logic [2:0]       in_op;
    logic [AW-1:0]    in_rd;
    logic             in_wr_en;
    logic             in_flags_en;

    logic             wb_valid;
    logic             wb_ready;
    logic             wb_we;
    logic [AW-1:0]    wb_addr;
    logic [WIDTH-1:0] wb_data;

    modport master (
        output in_valid, in_result, in_cout, in_overflow, in_op, in_rd, in_wr_en, in_flags_en,
        input  in_ready,
        output wb_ready,
        input  wb_valid, wb_we, wb_addr, wb_data
    );

    modport slave (
        input  in_valid, in_result, in_cout, in_overflow, in_op, in_rd, in_wr_en, in_flags_en,
        output in_ready,
        input  wb_ready,
        output wb_valid, wb_we, wb_addr, wb_data
    );

endinterface

// File: rtl/wb_fifo2.sv
// Two-entry synchronous FIFO of writeback entries. Exposes the head entry and
// the occupancy; push into a full FIFO and pop from an empty one are dropped.
module wb_fifo2
    import alu_pkg::*;
(
    input  logic      clk,
    input  logic      rst,
    input  logic      push,
    input  wb_entry_t push_data,
    input  logic      pop,
    output wb_entry_t head,
    output logic [1:0] count
);

    wb_entry_t  mem_q [2];
    wb_entry_t  mem_d [2];
    logic       wr_ptr_q, wr_ptr_d;
    logic       rd_ptr_q, rd_ptr_d;
    logic [1:0] count_q, count_d;
    logic       push_ok_s;
    logic       pop_ok_s;

    // Next-state: qualify push/pop against occupancy, write slot, advance pointers.
    always_comb begin
        mem_d[0] = mem_q[0];
        mem_d[1] = mem_q[1];
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        push_ok_s = push & (count_q != 2'd2);
        pop_ok_s  = pop & (count_q != 2'd0);

        if (push_ok_s) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = ~wr_ptr_q;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end

        if (pop_ok_s) begin
            rd_ptr_d = ~rd_ptr_q;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end

        case ({push_ok_s, pop_ok_s})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    // State registers; reset empties the FIFO and clears the storage.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            mem_q[0] <= mem_d[0];
            mem_q[1] <= mem_d[1];
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign head  = mem_q[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/alu_writeback_stage.sv
// ALU writeback stage: captures each ALU result with its flags into a 2-entry
// FIFO, presents the head to the register-file write port, and on retire
// updates the NZCV status register and the retire counter.
module alu_writeback_stage
    import alu_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int AW    = 3,
    parameter int DEPTH = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    alu_writeback_stage_if.slave bus,
    output logic                 flag_n,
    output logic                 flag_z,
    output logic                 flag_c,
    output logic                 flag_v,
    output logic [15:0]          retire_cnt
);

    // The entry layout is fixed by the shared package; refuse to build any other shape.
    if (DEPTH != 2) begin : g_depth_check
        $error("alu_writeback_stage: DEPTH must be 2");
    end
    if (WIDTH != alu_pkg::WIDTH || AW != alu_pkg::AW) begin : g_width_check
        $error("alu_writeback_stage: WIDTH/AW must match alu_pkg");
    end

    wb_entry_t   new_entry_s;
    wb_entry_t   head_s;
    wb_entry_t   shown_s;
    wb_entry_t   hold_q, hold_d;
    logic [1:0]  count_s;
    logic        in_ready_s;
    logic        wb_valid_s;
    logic        push_s;
    logic        pop_s;
    logic [3:0]  nzcv_q, nzcv_d;
    logic [15:0] retire_cnt_q, retire_cnt_d;

    // Handshake qualification; in_ready depends only on registered occupancy.
    always_comb begin
        in_ready_s = (count_s != 2'd2);
        wb_valid_s = (count_s != 2'd0);
        push_s     = bus.in_valid & in_ready_s;
        pop_s      = wb_valid_s & bus.wb_ready;
    end

    // Build the entry to store, resolving its flags now so retire is a plain load.
    always_comb begin
        new_entry_s          = '0;
        new_entry_s.result   = bus.in_result;
        new_entry_s.rd       = bus.in_rd;
        new_entry_s.wr_en    = bus.in_wr_en;
        new_entry_s.flags_en = bus.in_flags_en;
        new_entry_s.nzcv     = calc_nzcv(bus.in_result, bus.in_op, bus.in_cout, bus.in_overflow);
    end

    wb_fifo2 u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push_s),
        .push_data (new_entry_s),
        .pop       (pop_s),
        .head      (head_s),
        .count     (count_s)
    );

    // Remember the last presented head so wb_addr/wb_data hold steady once the FIFO drains.
    always_comb begin
        hold_d  = hold_q;
        shown_s = hold_q;
        if (wb_valid_s) begin
            hold_d  = head_s;
            shown_s = head_s;
        end else begin
            hold_d  = hold_q;
            shown_s = hold_q;
        end
    end

    // Retire side effects: status register loads on flags_en, counter bumps on every pop.
    always_comb begin
        nzcv_d       = nzcv_q;
        retire_cnt_d = retire_cnt_q;
        if (pop_s) begin
            retire_cnt_d = retire_cnt_q + 16'd1;
            if (head_s.flags_en) begin
                nzcv_d = head_s.nzcv;
            end else begin
                nzcv_d = nzcv_q;
            end
        end else begin
            retire_cnt_d = retire_cnt_q;
        end
    end

    // Status, retire counter and held-head registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_q       <= '0;
            nzcv_q       <= 4'b0000;
            retire_cnt_q <= 16'd0;
        end else begin
            hold_q       <= hold_d;
            nzcv_q       <= nzcv_d;
            retire_cnt_q <= retire_cnt_d;
        end
    end

    assign bus.in_ready = in_ready_s;
    assign bus.wb_valid = wb_valid_s;
    assign bus.wb_we    = wb_valid_s & shown_s.wr_en;
    assign bus.wb_addr  = shown_s.rd;
    assign bus.wb_data  = shown_s.result;

    assign flag_n     = nzcv_q[FLAG_N];
    assign flag_z     = nzcv_q[FLAG_Z];
    assign flag_c     = nzcv_q[FLAG_C];
    assign flag_v     = nzcv_q[FLAG_V];
    assign retire_cnt = retire_cnt_q;

endmodule
